// File: rtl/matrix_stream_ctrl.sv
// matrix_stream_ctrl: streams one WIDTH x HEIGHT matrix pass through a registered output
// stage, tagging row/frame ends and emitting counter-stage advance strobes.
module matrix_stream_ctrl #(
    parameter int MATRIXSIZE_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MATRIXSIZE_W-1:0] WIDTH,
    input  logic [MATRIXSIZE_W-1:0] HEIGHT,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_row_last,
    output logic                    out_frame_last,
    input  logic                    out_ready,
    output logic                    enable_pixel_count,
    output logic                    enable_slice_count,
    output logic                    busy,
    output logic                    done
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam logic [MATRIXSIZE_W-1:0] ONE = MATRIXSIZE_W'(1);
    state_t state_q, state_d;
    logic [MATRIXSIZE_W-1:0] width_q, width_d, height_q, height_d;
    logic [MATRIXSIZE_W-1:0] col_q, col_d, row_q, row_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic out_valid_q, out_valid_d, row_last_q, row_last_d, frame_last_q, frame_last_d;
    logic accept, col_last, row_last;
    assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
    assign accept = in_valid && in_ready;
    assign col_last = col_q == width_q - ONE;
    assign row_last = row_q == height_q - ONE;
    assign enable_pixel_count = accept;
    assign enable_slice_count = accept;
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign out_row_last = row_last_q;
    assign out_frame_last = frame_last_q;
    always_comb begin
        state_d = state_q;
        width_d = width_q;
        height_d = height_q;
        col_d = col_q;
        row_d = row_q;
        out_valid_d = out_valid_q;
        out_data_d = out_data_q;
        row_last_d = row_last_q;
        frame_last_d = frame_last_q;
        case (state_q)
            IDLE: if (start) begin
                width_d = WIDTH;
                height_d = HEIGHT;
                col_d = '0;
                row_d = '0;
                state_d = (WIDTH == '0 || HEIGHT == '0) ? DONE : RUN;
            end
            RUN: state_d = (accept && col_last && row_last) ? DRAIN : RUN;
            // leave only once the final element has actually been taken downstream
            DRAIN: state_d = out_valid_q ? DRAIN : DONE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            col_d = col_last ? '0 : col_q + ONE;
            row_d = col_last ? row_q + ONE : row_q;
            out_valid_d = 1'b1;
            out_data_d = in_data;
            row_last_d = col_last;
            frame_last_d = col_last && row_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            width_q <= '0;
            height_q <= '0;
            col_q <= '0;
            row_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            row_last_q <= 1'b0;
            frame_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            width_q <= width_d;
            height_q <= height_d;
            col_q <= col_d;
            row_q <= row_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            row_last_q <= row_last_d;
            frame_last_q <= frame_last_d;
        end
    end
endmodule

// File: tb/tb_matrix_stream_ctrl.sv
// tb_matrix_stream_ctrl: table-driven and randomized matrix passes checked against an
// element-order scoreboard, plus hand sequences for backpressure, zero size and reset.
module tb_matrix_stream_ctrl;
    localparam int MW = 16;
    localparam int DW = 32;
    logic clk = 1'b0;
    logic rst, start, in_valid, in_ready, out_valid, out_row_last, out_frame_last, out_ready;
    logic enable_pixel_count, enable_slice_count, busy, done;
    logic [MW-1:0] WIDTH, HEIGHT;
    logic [DW-1:0] in_data, out_data;
    logic [DW-1:0] data_v [64];
    int checks = 0;
    int fails = 0;

    typedef struct {
        int w; int h; int pv; int pr; bit poke; bit full; int exp_acc;
    } pass_t;
    pass_t tbl [7];

    matrix_stream_ctrl #(.MATRIXSIZE_W(MW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_row_last(out_row_last),
        .out_frame_last(out_frame_last), .out_ready(out_ready),
        .enable_pixel_count(enable_pixel_count), .enable_slice_count(enable_slice_count),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_pass(input int w, input int h);
        @(negedge clk);
        start = 1'b1;
        WIDTH = MW'(w);
        HEIGHT = MW'(h);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Reference: the i-th element accepted must be the i-th emitted, with row/frame
    // markers derived from i alone; done follows the final handshake by two cycles.
    task automatic stream(input int w, input int h, input int pv, input int pr,
                          input bit poke, input bit full, input int exp_acc);
        int n, acc, outn, cyc, hs;
        bit hold, got_done;
        logic [DW-1:0] pd;
        logic prl, pfl;
        n = w * h; acc = 0; outn = 0; cyc = 0; hs = -10; hold = 0; got_done = 0;
        pd = '0; prl = 0; pfl = 0;
        for (int i = 0; i < n; i++) data_v[i] = $urandom;
        start_pass(w, h);
        while (!got_done && cyc < 2000) begin
            in_valid = (acc < n) && ($urandom_range(99) < pv);
            in_data = (acc < n) ? data_v[acc] : $urandom;
            out_ready = $urandom_range(99) < pr;
            start = poke && cyc == 2;
            WIDTH = poke ? MW'(7) : MW'(w);
            #1;
            if (hold) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, pd);
                chk("stall_row", out_row_last, prl);
                chk("stall_frame", out_frame_last, pfl);
            end
            chk("in_ready", in_ready, (acc < n) && (!out_valid || out_ready));
            chk("en_pixel", enable_pixel_count, in_valid && in_ready);
            chk("en_slice", enable_slice_count, in_valid && in_ready);
            chk("busy", busy, 1);
            if (done) begin
                chk("done_latency", cyc, hs + 2);
                chk("outputs_seen", outn, n);
                chk("accepts", acc, exp_acc);
                got_done = 1;
            end else begin
                if (in_valid && in_ready) begin
                    if (full) chk("consecutive_accept", cyc, acc);
                    acc++;
                end
                if (out_valid && out_ready) begin
                    if (outn < n) begin
                        chk("out_data", out_data, data_v[outn]);
                        chk("row_last", out_row_last, (outn % w) == w - 1);
                        chk("frame_last", out_frame_last, outn == n - 1);
                    end
                    if (outn == n - 1) hs = cyc;
                    outn++;
                end
                hold = out_valid && !out_ready;
                pd = out_data; prl = out_row_last; pfl = out_frame_last;
            end
            start = 1'b0;
            if (!got_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!got_done) begin
            checks++; fails++;
            $display("FAIL done_timeout: got no done expected done within 2000 cycles");
        end
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post_done", done, 0);
            chk("post_busy", busy, 0);
            chk("post_valid", out_valid, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 0; WIDTH = '0; HEIGHT = '0;
        in_valid = 1'b1; in_data = '1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_flags", {out_row_last, out_frame_last}, 0);
        chk("rst_enables", {enable_pixel_count, enable_slice_count}, 0);
        chk("rst_busy_done", {busy, done}, 0);
        rst = 1'b0; in_valid = 1'b0;

        tbl[0] = '{3, 2, 100, 100, 1'b0, 1'b1, 6};
        tbl[1] = '{1, 3, 100, 100, 1'b0, 1'b1, 3};
        tbl[2] = '{2, 2, 80, 80, 1'b1, 1'b0, 4};
        tbl[3] = '{4, 3, 60, 50, 1'b0, 1'b0, 12};
        tbl[4] = '{3, 3, 100, 30, 1'b0, 1'b0, 9};
        tbl[5] = '{5, 1, 40, 100, 1'b0, 1'b0, 5};
        tbl[6] = '{1, 1, 100, 100, 1'b0, 1'b1, 1};
        for (int t = 0; t < 7; t++)
            stream(tbl[t].w, tbl[t].h, tbl[t].pv, tbl[t].pr, tbl[t].poke, tbl[t].full, tbl[t].exp_acc);

        // backpressure: element held for three stalled cycles, then drained with full throughput
        start_pass(2, 1);
        in_valid = 1'b1; in_data = 32'hAAAA_0001; out_ready = 1'b0;
        @(negedge clk);
        in_data = 32'hBBBB_0002;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, 32'hAAAA_0001);
            chk("bp_flags", {out_row_last, out_frame_last}, 2'b00);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_enable", enable_pixel_count, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_resume_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("bp_second_data", out_data, 32'hBBBB_0002);
        chk("bp_second_flags", {out_valid, out_row_last, out_frame_last}, 3'b111);
        begin
            int k;
            k = 0;
            while (!done && k < 10) begin
                @(negedge clk);
                #1;
                k++;
            end
            chk("bp_done", done, 1);
            chk("bp_done_cycles", k, 2);
        end

        // zero width: straight to DONE, nothing accepted
        @(negedge clk);
        start_pass(0, 4);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("zero_done", done, 1);
        chk("zero_in_ready", in_ready, 0);
        chk("zero_valid", out_valid, 0);
        chk("zero_enable", enable_pixel_count, 0);
        @(negedge clk);
        #1;
        chk("zero_done_pulse", done, 0);
        chk("zero_idle", busy, 0);
        chk("zero_valid2", out_valid, 0);
        in_valid = 1'b0;

        // reset mid-pass with an element buffered
        start_pass(2, 2);
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("mid_buffered", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;
        stream(2, 2, 100, 100, 1'b0, 1'b1, 4);

        for (int r = 0; r < 10; r++) begin
            int w, h;
            w = $urandom_range(1, 4);
            h = $urandom_range(1, 4);
            stream(w, h, $urandom_range(30, 100), $urandom_range(30, 100), 1'b0, 1'b0, w * h);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
